// File: rtl/bt_arb_pkg.sv
// bt_arb_pkg: shared widths, header field location and FSM state types for
// the bluetile client arbiter.
package bt_arb_pkg;

  localparam int BT_WORD_W  = 32;
  localparam int BT_LEN_LSB = 0;
  localparam int BT_LEN_W   = 8;

  typedef enum logic {REQ_IDLE, REQ_BUSY} req_state_t;
  typedef enum logic {RSP_IDLE, RSP_BUSY} rsp_state_t;

  // One word on a valid/accept style channel
  typedef struct packed {
    logic                 vld;
    logic [BT_WORD_W-1:0] word;
  } bt_beat_t;

  // Payload length carried in a packet header word
  function automatic logic [BT_LEN_W-1:0] bt_hdr_len(input logic [BT_WORD_W-1:0] hdr);
    return hdr[BT_LEN_LSB +: BT_LEN_W];
  endfunction

endpackage

// File: rtl/bt_arb_order_fifo.sv
// bt_arb_order_fifo: small synchronous FIFO holding the client index of each
// request packet sent upstream, so responses can be routed back in order.
// DEPTH must be a power of 2; pointers wrap naturally.
module bt_arb_order_fifo
#(
  parameter int CW    = 2,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [CW-1:0] push_data,
  input  logic          pop,
  output logic [CW-1:0] head,
  output logic          full,
  output logic          empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [CW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; simultaneous push/pop leaves count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage array; contents need no reset since empty gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bluetile_client_arbiter.sv
// bluetile_client_arbiter: shares one bluetile client port among NUM_CLIENTS
// GPIO processors. Request packets are granted whole, one client at a time;
// responses return in request order and are steered by an order FIFO.
// Config macro BT_ARB_FIXED_PRIO_EN: when defined the lowest-index valid
// client always wins; otherwise round-robin from the client after the last
// one served.
module bluetile_client_arbiter
  import bt_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ORDER_DEPTH = 8
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [BT_WORD_W*NUM_CLIENTS-1:0] cli_req_DOUT,
  input  logic [NUM_CLIENTS-1:0]           cli_req_valid,
  output logic [NUM_CLIENTS-1:0]           cli_req_accept,
  output logic [BT_WORD_W*NUM_CLIENTS-1:0] cli_rsp_DIN,
  input  logic [NUM_CLIENTS-1:0]           cli_rsp_canaccept,
  output logic [NUM_CLIENTS-1:0]           cli_rsp_commit,
  output logic [BT_WORD_W-1:0]             net_req_DOUT,
  output logic                             net_req_valid,
  input  logic                             net_req_accept,
  input  logic [BT_WORD_W-1:0]             net_rsp_DIN,
  output logic                             net_rsp_canaccept,
  input  logic                             net_rsp_commit
);
  localparam int CW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  typedef logic [BT_LEN_W-1:0] cnt_t;

  logic [NUM_CLIENTS-1:0][BT_WORD_W-1:0] req_word;
  assign req_word = cli_req_DOUT;

  // request side
  req_state_t    req_state, req_state_nx;
  logic [CW-1:0] grant, grant_nx, pick;
  logic          pick_ok, grant_go;
  logic          req_hdr;   // next word from the granted client is a header
  cnt_t          req_rem, req_len;
  logic          req_xfer, req_last;
  bt_beat_t      req_beat;

  // response side
  rsp_state_t    rsp_state, rsp_state_nx;
  cnt_t          rsp_rem, rsp_len;
  logic          rsp_xfer, rsp_last;

  // order FIFO
  logic [CW-1:0] head;
  logic          fifo_full, fifo_empty;

`ifdef BT_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest valid index wins, no rotation state needed
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = NUM_CLIENTS-1; k >= 0; k--) begin
      if (cli_req_valid[k]) begin
        pick    = CW'(k);
        pick_ok = 1'b1;
      end
    end
  end
`else
  logic [CW-1:0] ptr;

  // Round-robin: first valid client at or after ptr (descending scan so the
  // closest one to ptr is written last)
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = NUM_CLIENTS-1; k >= 0; k--) begin
      if (cli_req_valid[(int'(ptr) + k) % NUM_CLIENTS]) begin
        pick    = CW'((int'(ptr) + k) % NUM_CLIENTS);
        pick_ok = 1'b1;
      end
    end
  end

  // Rotation pointer moves past the client whose packet just finished
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      ptr <= '0;
    else if (req_last)
      ptr <= (grant == CW'(NUM_CLIENTS-1)) ? '0 : grant + 1'b1;
  end
`endif

  // Request FSM next state and upstream mux; a grant is only taken in IDLE,
  // which also forces one idle cycle between packets
  always_comb begin
    req_state_nx = req_state;
    grant_nx     = grant;
    grant_go     = 1'b0;
    req_beat     = '0;
    if (req_state == REQ_BUSY) begin
      req_beat.vld  = cli_req_valid[grant];
      req_beat.word = req_word[grant];
    end
    req_xfer = req_beat.vld && net_req_accept;
    req_len  = bt_hdr_len(req_beat.word);
    req_last = req_xfer && (req_hdr ? (req_len == '0) : (req_rem == cnt_t'(1)));
    case (req_state)
      REQ_IDLE: begin
        if (pick_ok && !fifo_full) begin
          req_state_nx = REQ_BUSY;
          grant_nx     = pick;
          grant_go     = 1'b1;
        end
      end
      REQ_BUSY: if (req_last) req_state_nx = REQ_IDLE;
      default:  req_state_nx = REQ_IDLE;
    endcase
  end

  // Request FSM state, grant register and payload word counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_state <= REQ_IDLE;
      grant     <= '0;
      req_hdr   <= 1'b0;
      req_rem   <= '0;
    end else begin
      req_state <= req_state_nx;
      grant     <= grant_nx;
      if (grant_go) begin
        req_hdr <= 1'b1;
      end else if (req_xfer) begin
        req_hdr <= 1'b0;
        req_rem <= req_hdr ? req_len : req_rem - cnt_t'(1);
      end
    end
  end

  assign net_req_valid = req_beat.vld;
  assign net_req_DOUT  = req_beat.word;

  bt_arb_order_fifo #(
    .CW    (CW),
    .DEPTH (ORDER_DEPTH)
  ) u_order_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (req_xfer && req_hdr),
    .push_data (grant),
    .pop       (rsp_last),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Response FSM: back-pressure from the head client passes straight through,
  // and nothing is accepted with no outstanding request
  always_comb begin
    rsp_state_nx      = rsp_state;
    net_rsp_canaccept = !fifo_empty && cli_rsp_canaccept[head];
    rsp_xfer          = net_rsp_canaccept && net_rsp_commit;
    rsp_len           = bt_hdr_len(net_rsp_DIN);
    rsp_last          = rsp_xfer &&
                        ((rsp_state == RSP_IDLE) ? (rsp_len == '0) : (rsp_rem == cnt_t'(1)));
    case (rsp_state)
      RSP_IDLE: if (rsp_xfer && !rsp_last) rsp_state_nx = RSP_BUSY;
      RSP_BUSY: if (rsp_last) rsp_state_nx = RSP_IDLE;
      default:  rsp_state_nx = RSP_IDLE;
    endcase
  end

  // Response FSM state and remaining payload count
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_state <= RSP_IDLE;
      rsp_rem   <= '0;
    end else begin
      rsp_state <= rsp_state_nx;
      if (rsp_xfer)
        rsp_rem <= (rsp_state == RSP_IDLE) ? rsp_len : rsp_rem - cnt_t'(1);
    end
  end

  // Per-client lanes: accept/commit decode and response broadcast
  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_lane
    assign cli_req_accept[i]                      = req_xfer && (grant == CW'(i));
    assign cli_rsp_commit[i]                      = rsp_xfer && (head == CW'(i));
    assign cli_rsp_DIN[BT_WORD_W*i +: BT_WORD_W]  = net_rsp_DIN;
  end

endmodule

// File: tb/tb_bluetile_client_arbiter.sv
// tb_bluetile_client_arbiter: directed tests with a queue-based reference
// model of packet arbitration and in-order response routing, compared every
// cycle, plus literal expectations on grant/route order.
module tb_bluetile_client_arbiter;
  localparam int N = 4;
  localparam int D = 8;

  logic            CLK = 1'b0;
  logic            RST;
  logic [32*N-1:0] cli_req_DOUT;
  logic [N-1:0]    cli_req_valid, cli_req_accept;
  logic [32*N-1:0] cli_rsp_DIN;
  logic [N-1:0]    cli_rsp_canaccept, cli_rsp_commit;
  logic [31:0]     net_req_DOUT;
  logic            net_req_valid, net_req_accept;
  logic [31:0]     net_rsp_DIN;
  logic            net_rsp_canaccept, net_rsp_commit;

  always #5 CLK = ~CLK;

  bluetile_client_arbiter #(.NUM_CLIENTS(N), .ORDER_DEPTH(D)) dut (
    .CLK(CLK), .RST(RST),
    .cli_req_DOUT(cli_req_DOUT), .cli_req_valid(cli_req_valid), .cli_req_accept(cli_req_accept),
    .cli_rsp_DIN(cli_rsp_DIN), .cli_rsp_canaccept(cli_rsp_canaccept), .cli_rsp_commit(cli_rsp_commit),
    .net_req_DOUT(net_req_DOUT), .net_req_valid(net_req_valid), .net_req_accept(net_req_accept),
    .net_rsp_DIN(net_rsp_DIN), .net_rsp_canaccept(net_rsp_canaccept), .net_rsp_commit(net_rsp_commit)
  );

  int checks = 0;
  int errors = 0;

  // stimulus sources
  logic [31:0] cq [N][$];
  logic [31:0] rsp_q [$];
  logic [N-1:0] acc_snap = '0;
  bit           rsp_snap = 1'b0;

  // reference model state
  bit m_busy, m_hdr;
  int m_g, m_left, m_ptr;
  int oq [$];
  bit r_in;
  int r_left;

  // observation logs
  int hdr_log [$];
  int rsp_log [$];
  logic [31:0] rsp_wlog [$];
  int xfer_cnt, first_x, last_x, cyc;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] v, input int ptr);
`ifdef BT_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
    if (ptr < 0) return 0;
`else
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
`endif
    return 0;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      cli_req_valid[i]       = (cq[i].size() != 0);
      cli_req_DOUT[32*i +: 32] = (cq[i].size() != 0) ? cq[i][0] : 32'h0;
    end
    net_rsp_commit = (rsp_q.size() != 0);
    net_rsp_DIN    = (rsp_q.size() != 0) ? rsp_q[0] : 32'h0;
  endtask

  // Source side: retire words transferred at this edge, present the next ones
  always @(posedge CLK) begin
    #1;
    for (int i = 0; i < N; i++)
      if (acc_snap[i] && cq[i].size() != 0) void'(cq[i].pop_front());
    if (rsp_snap && rsp_q.size() != 0) void'(rsp_q.pop_front());
    drive();
  end

  // Compare DUT with the model every cycle, then advance the model by the
  // transfers that the coming edge will perform
  always @(negedge CLK) begin : cmp
    logic [N-1:0] e_acc, e_com;
    bit e_nv, e_rca, pop;
    int len, idx;
    logic [31:0] w;
    cyc++;
    if (RST) begin
      m_busy = 0; m_hdr = 0; m_g = 0; m_left = 0; m_ptr = 0;
      oq.delete(); r_in = 0; r_left = 0;
      acc_snap = '0; rsp_snap = 0;
      chk("rst_net_req_valid", net_req_valid, 0);
      chk("rst_cli_req_accept", cli_req_accept, 0);
      chk("rst_net_rsp_canaccept", net_rsp_canaccept, 0);
      chk("rst_cli_rsp_commit", cli_rsp_commit, 0);
    end else begin
      e_nv  = m_busy && cli_req_valid[m_g];
      e_acc = '0;
      if (e_nv && net_req_accept) e_acc[m_g] = 1'b1;
      e_rca = 0;
      if (oq.size() != 0) e_rca = cli_rsp_canaccept[oq[0]];
      e_com = '0;
      if (e_rca && net_rsp_commit) e_com[oq[0]] = 1'b1;

      chk("net_req_valid", net_req_valid, e_nv);
      if (e_nv) chk("net_req_DOUT", net_req_DOUT, cli_req_DOUT[32*m_g +: 32]);
      chk("cli_req_accept", cli_req_accept, e_acc);
      chk("net_rsp_canaccept", net_rsp_canaccept, e_rca);
      chk("cli_rsp_commit", cli_rsp_commit, e_com);
      chk("cli_rsp_DIN", cli_rsp_DIN, {N{net_rsp_DIN}});

      acc_snap = cli_req_accept;
      rsp_snap = net_rsp_canaccept && net_rsp_commit;

      idx = -1;
      for (int i = 0; i < N; i++) if (cli_req_accept[i]) idx = i;
      if (idx >= 0) begin
        if (xfer_cnt == 0) first_x = cyc;
        last_x = cyc;
        xfer_cnt++;
        if (m_busy && m_hdr) hdr_log.push_back(idx);
      end
      idx = -1;
      for (int i = 0; i < N; i++) if (cli_rsp_commit[i]) idx = i;
      if (idx >= 0) begin
        rsp_log.push_back(idx);
        rsp_wlog.push_back(net_rsp_DIN);
      end

      pop = 0;
      if (e_com != 0) begin
        if (!r_in) begin
          len = int'(net_rsp_DIN[7:0]);
          if (len == 0) pop = 1;
          else begin r_in = 1; r_left = len; end
        end else begin
          r_left--;
          if (r_left == 0) begin pop = 1; r_in = 0; end
        end
      end

      if (!m_busy) begin
        if (cli_req_valid != 0 && oq.size() < D) begin
          m_g = model_pick(cli_req_valid, m_ptr);
          m_busy = 1; m_hdr = 1;
        end
      end else if (e_acc != 0) begin
        w = cli_req_DOUT[32*m_g +: 32];
        if (m_hdr) begin
          oq.push_back(m_g);
          len = int'(w[7:0]);
          if (len == 0) begin m_busy = 0; m_ptr = (m_g + 1) % N; end
          else begin m_left = len; m_hdr = 0; end
        end else begin
          m_left--;
          if (m_left == 0) begin m_busy = 0; m_ptr = (m_g + 1) % N; end
        end
      end
      if (pop) void'(oq.pop_front());
    end
  end

  task automatic send_pkt(input int c, input int len, input logic [31:0] base);
    cq[c].push_back({8'(c), base[15:0], 8'(len)});
    for (int k = 1; k <= len; k++) cq[c].push_back(base + 32'(k));
  endtask

  task automatic push_rsp(input int len, input logic [31:0] base);
    rsp_q.push_back({base[23:0], 8'(len)});
    for (int k = 1; k <= len; k++) rsp_q.push_back(base + 32'(k));
  endtask

  function automatic bit quiet();
    for (int i = 0; i < N; i++) if (cq[i].size() != 0) return 0;
    return !m_busy && rsp_q.size() == 0;
  endfunction

  task automatic wait_quiet(input string name);
    int n = 0;
    while (!quiet() && n < 200) begin @(posedge CLK); #2; n++; end
    checks++;
    if (!quiet()) begin errors++; $display("FAIL %s timeout actual=busy required=idle", name); end
  endtask

  task automatic clear_logs();
    hdr_log.delete(); rsp_log.delete(); rsp_wlog.delete(); xfer_cnt = 0;
  endtask

  task automatic pulse_reset();
    @(posedge CLK); #2;
    RST = 1'b1;
    for (int i = 0; i < N; i++) cq[i].delete();
    rsp_q.delete();
    drive();
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    clear_logs();
  endtask

  initial begin
    int n;
    RST = 1'b1;
    net_req_accept = 1'b0;
    cli_rsp_canaccept = '0;
    cli_req_valid = '0; cli_req_DOUT = '0; net_rsp_commit = 1'b0; net_rsp_DIN = '0;
    xfer_cnt = 0; cyc = 0; first_x = 0; last_x = 0;
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    net_req_accept = 1'b1;
    cli_rsp_canaccept = '1;

    // 1: client 1, LEN=2, back-to-back upstream
    send_pkt(1, 2, 32'h0000_1100);
    wait_quiet("t1_req");
    chk("t1_hdr_count", hdr_log.size(), 1);
    chk("t1_hdr_client", hdr_log[0], 1);
    chk("t1_words", xfer_cnt, 3);
    chk("t1_b2b", last_x - first_x, 2);
    push_rsp(0, 32'h0000_AA00);
    wait_quiet("t1_rsp");
    chk("t1_rsp_route", rsp_log.size() == 1 ? rsp_log[0] : -1, 1);

    // 2: round-robin contention between 0 and 2
    pulse_reset();
    send_pkt(0, 0, 32'h0000_2000);
    send_pkt(0, 0, 32'h0000_2001);
    send_pkt(2, 0, 32'h0000_2200);
    wait_quiet("t2_req");
    chk("t2_hdr_count", hdr_log.size(), 3);
    chk("t2_order0", hdr_log[0], 0);
    chk("t2_order1", hdr_log[1], 2);
    chk("t2_order2", hdr_log[2], 0);
    for (int k = 0; k < 3; k++) push_rsp(0, 32'h0000_B000);
    wait_quiet("t2_rsp");
    chk("t2_rsp_count", rsp_log.size(), 3);
    chk("t2_rsp1", rsp_log[1], 2);

    // 3: order FIFO full blocks new grants until a response completes
    clear_logs();
    for (int k = 0; k < 3; k++) begin send_pkt(0, 0, 32'h30); send_pkt(1, 0, 32'h31); end
    for (int k = 0; k < 2; k++) send_pkt(2, 0, 32'h32);
    wait_quiet("t3_fill");
    chk("t3_filled", hdr_log.size(), 8);
    send_pkt(3, 0, 32'h33);
    repeat (6) @(posedge CLK);
    #2;
    chk("t3_blocked", hdr_log.size(), 8);
    chk("t3_no_valid", net_req_valid, 0);
    push_rsp(0, 32'h0000_C000);
    wait_quiet("t3_unblock");
    chk("t3_granted", hdr_log.size(), 9);
    chk("t3_client3", hdr_log[8], 3);
    for (int k = 0; k < 8; k++) push_rsp(0, 32'h0000_C100);
    wait_quiet("t3_drain");
    chk("t3_rsp_count", rsp_log.size(), 9);

    // 4: responses routed in request order (2 then 0)
    clear_logs();
    send_pkt(2, 0, 32'h40);
    wait_quiet("t4_a");
    send_pkt(0, 0, 32'h41);
    wait_quiet("t4_b");
    push_rsp(1, 32'h0000_D000);
    push_rsp(1, 32'h0000_D100);
    wait_quiet("t4_rsp");
    chk("t4_count", rsp_log.size(), 4);
    chk("t4_w0", rsp_log[0], 2);
    chk("t4_w1", rsp_log[1], 2);
    chk("t4_w2", rsp_log[2], 0);
    chk("t4_w3", rsp_log[3], 0);

    // 5: head client back-pressure stalls the response without loss
    clear_logs();
    send_pkt(1, 0, 32'h50);
    wait_quiet("t5_req");
    cli_rsp_canaccept[1] = 1'b0;
    push_rsp(2, 32'h0000_0123);
    repeat (5) @(posedge CLK);
    #2;
    chk("t5_stall_canaccept", net_rsp_canaccept, 0);
    chk("t5_stall_none", rsp_log.size(), 0);
    cli_rsp_canaccept[1] = 1'b1;
    wait_quiet("t5_rsp");
    chk("t5_count", rsp_log.size(), 3);
    chk("t5_hdr", rsp_wlog[0], 32'h0001_2302);
    chk("t5_p1", rsp_wlog[1], 32'h0000_0124);
    chk("t5_p2", rsp_wlog[2], 32'h0000_0125);

    // 6: reset mid-packet abandons it; a fresh packet passes cleanly
    clear_logs();
    send_pkt(2, 4, 32'h0000_6000);
    n = 0;
    while (xfer_cnt < 2 && n < 50) begin @(posedge CLK); #2; n++; end
    chk("t6_two_words", xfer_cnt >= 2, 1);
    RST = 1'b1;
    for (int i = 0; i < N; i++) cq[i].delete();
    drive();
    @(negedge CLK);
    chk("t6_rst_valid", net_req_valid, 0);
    chk("t6_rst_accept", cli_req_accept, 0);
    chk("t6_rst_rsp", net_rsp_canaccept, 0);
    @(posedge CLK); #2 RST = 1'b0;
    clear_logs();
    repeat (2) @(posedge CLK);
    #2;
    chk("t6_fifo_empty", net_rsp_canaccept, 0);
    send_pkt(1, 1, 32'h0000_6100);
    wait_quiet("t6_req");
    chk("t6_hdr", hdr_log.size() == 1 ? hdr_log[0] : -1, 1);
    chk("t6_words", xfer_cnt, 2);
    push_rsp(0, 32'h0000_E000);
    wait_quiet("t6_rsp");
    chk("t6_rsp_route", rsp_log.size() == 1 ? rsp_log[0] : -1, 1);

    // 7: clients 0 and 3 continuously valid
    pulse_reset();
    for (int k = 0; k < 3; k++) begin send_pkt(0, 0, 32'h70); send_pkt(3, 0, 32'h73); end
    wait_quiet("t7_req");
    chk("t7_count", hdr_log.size(), 6);
`ifdef BT_ARB_FIXED_PRIO_EN
    chk("t7_g0", hdr_log[0], 0);
    chk("t7_g1", hdr_log[1], 0);
    chk("t7_g2", hdr_log[2], 0);
    chk("t7_g3", hdr_log[3], 3);
`else
    chk("t7_g0", hdr_log[0], 0);
    chk("t7_g1", hdr_log[1], 3);
    chk("t7_g2", hdr_log[2], 0);
    chk("t7_g3", hdr_log[3], 3);
`endif
    for (int k = 0; k < 6; k++) push_rsp(0, 32'h0000_F000);
    wait_quiet("t7_rsp");
    chk("t7_rsp_count", rsp_log.size(), 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
